// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and prefetch FSM encoding for the audio sample path.
package audio_pkg;
    localparam int ADDR_W   = 25;
    localparam int SAMPLE_W = 16;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} prefetch_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO; dout is the head word, zero while empty.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == CW'(DEPTH);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = clr ? '0 : wr_q + AW'(do_push);
        rd_d    = clr ? '0 : rd_q + AW'(do_pop);
        cnt_d   = clr ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
        dout    = empty ? '0 : mem[rd_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_q] <= din;
    end
endmodule

// File: rtl/audio_sample_prefetch.sv
// audio_sample_prefetch: loops a clip address range out of SDRAM, one read at a time,
// into a show-ahead FIFO popped by the I2S shifter; tracks fill level and underruns.
module audio_sample_prefetch #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 25
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [ADDR_W-1:0]             start_addr,
    input  logic [ADDR_W-1:0]             end_addr,
    output logic                          ram_rden,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic [audio_pkg::SAMPLE_W-1:0] ram_data,
    input  logic                          ram_ack,
    input  logic                          sample_req,
    output logic [audio_pkg::SAMPLE_W-1:0] sample_out,
    output logic                          sample_valid,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic [7:0]                    underrun_cnt
);
    import audio_pkg::*;

    prefetch_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, start_q, start_d, end_q, end_d, addr_nxt;
    logic              pend_q, pend_d, armed_q, armed_d;
    logic [7:0]        urun_q, urun_d;
    logic              push, pop, flush, discard, fifo_empty, fifo_full;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (armed_q && enable && !fifo_full && !pend_q && !load) ? READ : IDLE;
            READ:    state_d = !ram_ack ? READ : discard ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_rden     = state_q == READ;
        ram_addr     = addr_q;
        sample_valid = !fifo_empty;
        underrun_cnt = urun_q;
    end

    // A load during READ only arms the flush; the request is held until its ack.
    always_comb begin
        discard  = pend_q || load;
        push     = state_q == READ && ram_ack && !discard;
        pop      = sample_req && sample_valid;
        flush    = (load && state_q != READ) || state_q == DRAIN;
        addr_nxt = (addr_q == end_q) ? start_q : addr_q + 1'b1;
        start_d  = load ? start_addr : start_q;
        end_d    = load ? end_addr : end_q;
        armed_d  = armed_q || load;
        pend_d   = state_q == DRAIN ? 1'b0 : (load && state_q == READ) ? 1'b1 : pend_q;
        addr_d   = (load && state_q != READ) ? start_addr :
                   state_q == DRAIN ? start_q :
                   push ? addr_nxt : addr_q;
        urun_d   = (sample_req && !sample_valid && urun_q != 8'hFF) ? urun_q + 8'd1 : urun_q;
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
            urun_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            start_q <= start_d;
            end_q   <= end_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
            urun_q  <= urun_d;
        end
    end

    sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
        .clk   (clk50),
        .rst   (reset),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (ram_data),
        .dout  (sample_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fill_level)
    );
endmodule
